async_fifo_wr_ctrl: RTL and testbench

//   Write-domain control stage of the async FIFO. It owns the write pointer as a

---
 rtl/async_fifo_wr_ctrl.sv | 86 ++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain half of an async FIFO: write pointer (binary + Gray), read-pointer
// synchronizer, and registered full / almost_full / free-count indications.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   free_cnt
);

    localparam int              PW        = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH     = PW'(2**ADDR_WIDTH);
    localparam logic [PW-1:0]   AFULL_LVL = PW'(AFULL_THRESH);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("async_fifo_wr_ctrl: SYNC_STAGES must be at least 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > 2**ADDR_WIDTH) begin : g_bad_afull
            $error("async_fifo_wr_ctrl: AFULL_THRESH must be within 1..DEPTH");
        end
    endgenerate

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] rgray_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] used_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];

    // Handshake: wr_en is a request, wr_accept is its same-cycle grant; a write
    // takes effect at the edge only when wr_accept is high, a refused request is dropped.
    assign wr_accept = wr_en & ~full;
    assign wbin_next = wbin + PW'(wr_accept);
    assign waddr     = wbin[ADDR_WIDTH-1:0];
    assign rgray_s   = sync_q[SYNC_STAGES-1];
    assign used_next = wbin_next - rbin_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rbin_s         = '0;
        rbin_s[PW-1]   = rgray_s[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rgray_s[i];
        end
    end

    // Flags come from next-state values so full is visible the cycle after the filling write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            free_cnt    <= DEPTH;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wbin_next ^ (wbin_next >> 1);
            full        <= (used_next == DEPTH);
            almost_full <= (used_next >= AFULL_LVL);
            free_cnt    <= DEPTH - used_next;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl at ADDR_WIDTH=2: directed vectors plus a
// count-based reader model, checked by a negedge monitor against an expected queue.
`timescale 1ns/1ps
module tb_async_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] rptr_gray_async = 3'b000;
    logic       wr_accept;
    logic [1:0] waddr;
    logic [2:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [2:0] free_cnt;

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH   (2),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .rptr_gray_async (rptr_gray_async),
        .wr_accept       (wr_accept),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .free_cnt        (free_cnt)
    );

    always #5 clk = ~clk;

    // Expected entry layout: {wr_accept, waddr[1:0], wptr_gray[2:0], full, almost_full, free_cnt[2:0]}
    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rst_cnt = 0;
    bit          done = 1'b0;
    bit          timeout_flag = 1'b0;

    function automatic logic [2:0] to_gray(input int n);
        logic [2:0] b;
        b = 3'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic push(input string nm, input logic [10:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic vec(input string nm, input logic we, input logic [2:0] rg,
                       input logic acc, input logic [1:0] wa, input logic [2:0] g,
                       input logic f, input logic af, input logic [2:0] fc);
        @(posedge clk);
        #1;
        wr_en           = we;
        rptr_gray_async = rg;
        push(nm, {acc, wa, g, f, af, fc});
    endtask

    // Pulse reset between edges; outputs are checked before any further edge.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        wr_en           = 1'b0;
        rptr_gray_async = 3'b000;
        rst_cnt++;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        push(nm, {1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd4});
    endtask

    // Writer requests every cycle until target accepts; reader count trails the
    // writer's count by 4 cycles; flags see the reader 3 cycles late through the sync.
    task automatic run_model(input int target, input string nm);
        int   wcnt;
        int   used;
        int   r_now;
        int   n;
        int   rh[$];
        int   wh[$];
        logic acc;
        wcnt = 0;
        n    = 0;
        rh   = '{0, 0, 0};
        wh   = '{0, 0, 0, 0};
        while (wcnt < target && n < 200) begin
            @(posedge clk);
            #1;
            used  = wcnt - rh[0];
            r_now = wh[0];
            wr_en           = 1'b1;
            rptr_gray_async = to_gray(r_now);
            acc = (used != 4);
            push(nm, {acc, 2'(wcnt), to_gray(wcnt), used == 4, used >= 3, 3'(4 - used)});
            void'(rh.pop_front());
            rh.push_back(r_now);
            void'(wh.pop_front());
            wh.push_back(wcnt);
            wcnt += int'(acc);
            n++;
        end
        if (wcnt < target) timeout_flag = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        do_reset("reset");
        vec("fill0",     1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 3'd4);
        vec("fill1",     1, 3'b000, 1, 2'd1, 3'b001, 0, 0, 3'd3);
        vec("fill2",     1, 3'b000, 1, 2'd2, 3'b011, 0, 0, 3'd2);
        vec("fill3",     1, 3'b000, 1, 2'd3, 3'b010, 0, 1, 3'd1);
        vec("fill_full", 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd0);
        vec("fill_drop", 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd0);
        vec("rel0",      0, 3'b001, 0, 2'd0, 3'b110, 1, 1, 3'd0);
        vec("rel1",      0, 3'b001, 0, 2'd0, 3'b110, 1, 1, 3'd0);
        vec("rel2",      0, 3'b001, 0, 2'd0, 3'b110, 1, 1, 3'd0);
        vec("rel3",      0, 3'b001, 0, 2'd0, 3'b110, 0, 1, 3'd1);
        vec("sim0",      1, 3'b001, 1, 2'd0, 3'b110, 0, 1, 3'd1);
        vec("sim1",      1, 3'b011, 0, 2'd1, 3'b111, 1, 1, 3'd0);
        vec("sim2",      1, 3'b011, 0, 2'd1, 3'b111, 1, 1, 3'd0);
        vec("sim3",      1, 3'b011, 0, 2'd1, 3'b111, 1, 1, 3'd0);
        vec("sim4",      1, 3'b011, 1, 2'd1, 3'b111, 0, 1, 3'd1);
        vec("sim5",      0, 3'b011, 0, 2'd2, 3'b101, 1, 1, 3'd0);
        do_reset("reset_wrap");
        run_model(20, "wrap");
        do_reset("reset_op");
        run_model(5, "op");
        do_reset("reset_midop");
        vec("post_rst_wr",   1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 3'd4);
        vec("post_rst_next", 0, 3'b000, 0, 2'd1, 3'b001, 0, 0, 3'd3);
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion before 100000ns");
        $fatal(1, "watchdog expired");
    end

    logic [10:0] m_exp;
    logic [10:0] m_got;
    string       m_name;
    logic [2:0]  prev_gray = 3'b000;
    int          seen_rst = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_got  = {wr_accept, waddr, wptr_gray, full, almost_full, free_cnt};
            checks++;
            if (m_got !== m_exp) begin
                errors++;
                $display("FAIL %s: got acc=%b waddr=%0d gray=%b full=%b afull=%b free=%0d, expected acc=%b waddr=%0d gray=%b full=%b afull=%b free=%0d",
                         m_name, m_got[10], m_got[9:8], m_got[7:5], m_got[4], m_got[3], m_got[2:0],
                         m_exp[10], m_exp[9:8], m_exp[7:5], m_exp[4], m_exp[3], m_exp[2:0]);
            end
        end
        if (rst_cnt != seen_rst) begin
            seen_rst = rst_cnt;
        end else if (seen_rst > 0) begin
            checks++;
            if ($countones(wptr_gray ^ prev_gray) > 1) begin
                errors++;
                $display("FAIL gray_step: got %b -> %b, required at most one changed bit",
                         prev_gray, wptr_gray);
            end
        end
        prev_gray = wptr_gray;
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || timeout_flag) begin
                errors++;
                $display("FAIL drain: got pending=%0d timeout=%0b, required pending=0 timeout=0",
                         exp_q.size(), timeout_flag);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
